// File: rtl/alu_accum_5bit_if.sv
// Operand/result handshake bundle for the 5-bit accumulating ALU.
interface alu_accum_5bit_if;
   logic       in_valid;
   logic       in_ready;
   logic [4:0] in_data;
   logic       in_sub;
   logic       in_last;
   logic       out_valid;
   logic       out_ready;
   logic [4:0] out_sum;
   logic       out_ovf;
   logic       out_carry;
   logic [3:0] out_cnt;

   // Producer/consumer side (drives operands, accepts results)
   modport master (
      output in_valid, in_data, in_sub, in_last, out_ready,
      input  in_ready, out_valid, out_sum, out_ovf, out_carry, out_cnt
   );

   // Accumulator side
   modport slave (
      input  in_valid, in_data, in_sub, in_last, out_ready,
      output in_ready, out_valid, out_sum, out_ovf, out_carry, out_cnt
   );
endinterface

// File: rtl/alu_accum_5bit.sv
// Burst accumulator: adds/subtracts signed 5-bit operands, reports sum,
// sticky overflow, last carry and operand count once per burst.
module alu_accum_5bit #(
   parameter bit SAT = 1'b0
) (
   input  logic              clk,
   input  logic              rst_n,
   alu_accum_5bit_if.slave   bus
);
   localparam int unsigned W  = 5;
   localparam int unsigned CW = 4;
   localparam logic [CW-1:0] CNT_MAX = '1;

   typedef enum logic [1:0] {IDLE, ACC, OUT} state_e;

   state_e          state_q, state_d;
   logic [W-1:0]    acc_q, acc_d;
   logic            ovf_q, ovf_d;
   logic            carry_q, carry_d;
   logic [CW-1:0]   cnt_q, cnt_d;

   logic [W-1:0]    t_c;
   logic [W:0]      s_c;
   logic            ovf_c;
   logic [W-1:0]    sat_val_c;
   logic            in_ready_c;
   logic            in_xfer_c;
   logic            out_xfer_c;

   assign in_ready_c = (state_q != OUT);
   assign in_xfer_c  = bus.in_valid  && in_ready_c;
   assign out_xfer_c = bus.out_ready && (state_q == OUT);

   // Adder/subtractor with signed overflow and unsigned carry detection
   always_comb begin
      t_c       = bus.in_data ^ {W{bus.in_sub}};
      s_c       = {1'b0, acc_q} + {1'b0, t_c} + (W+1)'(bus.in_sub);
      ovf_c     = (acc_q[W-1] == t_c[W-1]) && (s_c[W-1] != acc_q[W-1]);
      sat_val_c = acc_q[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
   end

   // Next-state and datapath update
   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      ovf_d   = ovf_q;
      carry_d = carry_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE, ACC: begin
            if (in_xfer_c) begin
               acc_d   = (ovf_c && SAT) ? sat_val_c : s_c[W-1:0];
               carry_d = s_c[W];
               ovf_d   = ovf_q | ovf_c;
               cnt_d   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);
               state_d = bus.in_last ? OUT : ACC;
            end
         end
         OUT: begin
            if (out_xfer_c) begin
               state_d = IDLE;
               acc_d   = '0;
               ovf_d   = 1'b0;
               carry_d = 1'b0;
               cnt_d   = '0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and result registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         acc_q   <= '0;
         ovf_q   <= 1'b0;
         carry_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         ovf_q   <= ovf_d;
         carry_q <= carry_d;
         cnt_q   <= cnt_d;
      end
   end

   assign bus.in_ready  = in_ready_c;
   assign bus.out_valid = (state_q == OUT);
   assign bus.out_sum   = acc_q;
   assign bus.out_ovf   = ovf_q;
   assign bus.out_carry = carry_q;
   assign bus.out_cnt   = cnt_q;
endmodule
